rf_scoreboard_issue: RTL and testbench
======================================

Name: rf_scoreboard_issue

Overview:
Decode-side requester for the 32x32 two-read/one-write register file. It drives the register file read addresses and captures the returned operands into an issue register. A per-register busy scoreboard blocks RAW/WAW hazards against in-flight writes. Writeback completions clear scoreboard entries. Sits between fetch/decode and the execute stage of the RISC-V pipeline.

Parameters:
XLEN, 32, operand data width
NREG, 32, number of architectural registers (index width = clog2(NREG) = 5)
MAX_OUT, 4, maximum outstanding register-writing instructions (issued, not yet written back)

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
inst_valid_i  input  1  decoded instruction valid
inst_ready_o  output  1  instruction accepted when inst_valid_i && inst_ready_o at posedge
rs1_i  input  5  source register 1 index
rs2_i  input  5  source register 2 index
use_rs1_i  input  1  instruction reads rs1
use_rs2_i  input  1  instruction reads rs2
rd_i  input  5  destination register index
rd_wr_i  input  1  instruction writes rd
r_reg_p1_o  output  5  register file read address, port 1
r_reg_p2_o  output  5  register file read address, port 2
r_data_p1_i  input  XLEN  register file read data, port 1
r_data_p2_i  input  XLEN  register file read data, port 2
wb_en_i  input  1  writeback completion this cycle
wb_reg_i  input  5  register being written back
iss_valid_o  output  1  issue register holds a valid instruction
iss_ready_i  input  1  execute stage accepts issue register
iss_rs1_data_o  output  XLEN  captured operand 1
iss_rs2_data_o  output  XLEN  captured operand 2
iss_rd_o  output  5  destination index
iss_rd_wr_o  output  1  destination write enable (forced 0 when rd_i == 0)
out_cnt_o  output  3  current outstanding-write count

Behaviour:
- Reset (async): busy[*]=0, out_cnt=0, iss_valid_o=0, all iss_* data/index outputs = 0.
- r_reg_p1_o = rs1_i, r_reg_p2_o = rs2_i, combinational. The register file samples these at negedge clk. The block captures r_data_p*_i at the following posedge.
- Write-relevant: wr = rd_wr_i && rd_i != 0. busy[0] is never set.
- stall = (use_rs1_i && busy[rs1_i]) || (use_rs2_i && busy[rs2_i]) || (wr && busy[rd_i]) || (wr && out_cnt == MAX_OUT).
- inst_ready_o = !stall && (!iss_valid_o || iss_ready_i). Combinational, independent of inst_valid_i.
- Accept (posedge, inst_valid_i && inst_ready_o):
  - load the iss_* outputs and set iss_valid_o=1
  - if wr: set busy[rd_i] and increment out_cnt.
- No accept while iss_valid_o && iss_ready_i: iss_valid_o clears to 0 and data holds.
- No accept while iss_ready_i=0: the issue register holds all values.
- Writeback (posedge, wb_en_i && wb_reg_i != 0): clear busy[wb_reg_i] and decrement out_cnt.
  - Busy bit is evaluated from registered state only. A source matching wb_reg_i in the writeback cycle still stalls and is accepted the next cycle, once the regfile negedge write has landed.
- Simultaneous accept-with-wr and writeback:
  - same register: busy stays set (set wins).
  - out_cnt is unchanged (+1 - 1).
- Writeback to a non-busy register: ignored for busy; out_cnt does not decrement; out_cnt never underflows.
- Latency: accepted instruction appears on iss_* the cycle after acceptance. Back-to-back accepts are allowed when there are no hazards and iss_ready_i=1.
- Reset mid-operation: all scoreboard and issue state is discarded immediately. In-flight writebacks after reset are ignored per the non-busy rule.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - constants XLEN=32, NREG=32, REG_IDX_W=5
  - typedef reg_idx_t
  - typedef struct iss_pkt_t {rs1_data, rs2_data, rd, rd_wr}.
- One natural sub-module: rf_busy_table, holding the NREG busy bits with set/clear ports, set-wins rule and the x0 mask.

Test Plan:
- Reset, regfile x5=0x11, x6=0x22; issue add rd=7,rs1=5,rs2=6 with iss_ready_i=1 -> next cycle iss_valid_o=1, data 0x11/0x22, iss_rd_o=7, out_cnt_o=1.
- RAW: issue rd=7, then instr rs1=7 -> inst_ready_o=0.
  - wb_en_i=1, wb_reg_i=7 (write 0x99) at cycle N -> still stalled in N.
  - Accepted at N+1 with iss_rs1_data_o=0x99.
- x0: rd_wr_i=1, rd_i=0 -> no busy set, out_cnt stays 0, iss_rd_wr_o=0; following rs1=0 issues without stall.
- Capacity: 4 writes to x1..x4 with no writeback -> out_cnt=4.
  - 5th write (rd=8) stalls.
  - A non-writing instruction with no hazards is still accepted.
  - wb x1 -> rd=8 is accepted next cycle.
- Backpressure: hold iss_ready_i=0 -> iss_* stable and inst_ready_o=0. Release -> same packet consumed, then the next instruction is accepted.
- Assert reset while busy[7]=1 and iss_valid_o=1 -> outputs 0 immediately. A later wb_reg_i=7 leaves out_cnt_o=0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline constants and issue packet type
package rv_pipe_pkg;
  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    reg_idx_t        rd;
    logic            rd_wr;
  } iss_pkt_t;
endpackage

// File: rtl/rf_busy_table.sv
// rtl/rf_busy_table.sv - per-register busy bits; set beats clear, x0 never busy
module rf_busy_table
  import rv_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 clr_en_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  output logic [NREG-1:0]      busy_o
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en_i) w_busy_nxt[clr_idx_i] = 1'b0;
    if (set_en_i) w_busy_nxt[set_idx_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign busy_o = r_busy;
endmodule

// File: rtl/rf_scoreboard_issue.sv
// rtl/rf_scoreboard_issue.sv - regfile read requester with busy scoreboard and issue register
module rf_scoreboard_issue
  import rv_pipe_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_valid_i,
  output logic                 inst_ready_o,
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic                 use_rs1_i,
  input  logic                 use_rs2_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic                 rd_wr_i,
  output logic [REG_IDX_W-1:0] r_reg_p1_o,
  output logic [REG_IDX_W-1:0] r_reg_p2_o,
  input  logic [XLEN-1:0]      r_data_p1_i,
  input  logic [XLEN-1:0]      r_data_p2_i,
  input  logic                 wb_en_i,
  input  logic [REG_IDX_W-1:0] wb_reg_i,
  output logic                 iss_valid_o,
  input  logic                 iss_ready_i,
  output logic [XLEN-1:0]      iss_rs1_data_o,
  output logic [XLEN-1:0]      iss_rs2_data_o,
  output logic [REG_IDX_W-1:0] iss_rd_o,
  output logic                 iss_rd_wr_o,
  output logic [2:0]           out_cnt_o
);
  logic [NREG-1:0] w_busy;
  logic            w_wr;
  logic            w_stall;
  logic            w_accept;
  logic            w_acc_wr;
  logic            w_wb_eff;
  iss_pkt_t        r_iss;
  logic            r_iss_valid;
  logic [2:0]      r_out_cnt;

  assign r_reg_p1_o = rs1_i;
  assign r_reg_p2_o = rs2_i;

  assign w_wr    = rd_wr_i && (rd_i != '0);
  assign w_stall = (use_rs1_i && w_busy[rs1_i]) ||
                   (use_rs2_i && w_busy[rs2_i]) ||
                   (w_wr && w_busy[rd_i]) ||
                   (w_wr && (r_out_cnt == 3'(MAX_OUT)));

  assign inst_ready_o = !w_stall && (!r_iss_valid || iss_ready_i);
  assign w_accept     = inst_valid_i && inst_ready_o;
  assign w_acc_wr     = w_accept && w_wr;
  // Only a writeback that retires a tracked write may decrement the count.
  assign w_wb_eff     = wb_en_i && (wb_reg_i != '0) && w_busy[wb_reg_i];

  rf_busy_table u_busy (
    .clk       (clk),
    .reset     (reset),
    .set_en_i  (w_acc_wr),
    .set_idx_i (rd_i),
    .clr_en_i  (w_wb_eff),
    .clr_idx_i (wb_reg_i),
    .busy_o    (w_busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_out_cnt <= '0;
    else       r_out_cnt <= r_out_cnt + {2'b00, w_acc_wr} - {2'b00, w_wb_eff};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iss       <= '0;
      r_iss_valid <= 1'b0;
    end else if (w_accept) begin
      r_iss.rs1_data <= r_data_p1_i;
      r_iss.rs2_data <= r_data_p2_i;
      r_iss.rd       <= rd_i;
      r_iss.rd_wr    <= w_wr;
      r_iss_valid    <= 1'b1;
    end else if (iss_ready_i) begin
      r_iss_valid <= 1'b0;
    end
  end

  assign iss_valid_o    = r_iss_valid;
  assign iss_rs1_data_o = r_iss.rs1_data;
  assign iss_rs2_data_o = r_iss.rs2_data;
  assign iss_rd_o       = r_iss.rd;
  assign iss_rd_wr_o    = r_iss.rd_wr;
  assign out_cnt_o      = r_out_cnt;
endmodule

// File: tb/tb_rf_scoreboard_issue.sv
// tb/tb_rf_scoreboard_issue.sv - scoreboard bench for rf_scoreboard_issue
module tb_rf_scoreboard_issue;
  import rv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic        use_rs1_i, use_rs2_i, rd_wr_i;
  logic [4:0]  r_reg_p1_o, r_reg_p2_o;
  logic [31:0] r_data_p1_i, r_data_p2_i;
  logic        wb_en_i;
  logic [4:0]  wb_reg_i;
  logic        iss_valid_o, iss_ready_i;
  logic [31:0] iss_rs1_data_o, iss_rs2_data_o;
  logic [4:0]  iss_rd_o;
  logic        iss_rd_wr_o;
  logic [2:0]  out_cnt_o;

  logic [31:0] regs [32];
  logic [31:0] wb_data;
  iss_pkt_t    sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  rf_scoreboard_issue dut (
    .clk(clk), .reset(reset),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
    .rd_i(rd_i), .rd_wr_i(rd_wr_i),
    .r_reg_p1_o(r_reg_p1_o), .r_reg_p2_o(r_reg_p2_o),
    .r_data_p1_i(r_data_p1_i), .r_data_p2_i(r_data_p2_i),
    .wb_en_i(wb_en_i), .wb_reg_i(wb_reg_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_rs1_data_o(iss_rs1_data_o), .iss_rs2_data_o(iss_rs2_data_o),
    .iss_rd_o(iss_rd_o), .iss_rd_wr_o(iss_rd_wr_o), .out_cnt_o(out_cnt_o)
  );

  always #5 clk = ~clk;

  // Register file model: writeback lands at negedge, then the read ports sample.
  always @(negedge clk) begin
    if (wb_en_i && wb_reg_i != 5'd0) regs[wb_reg_i] = wb_data;
    r_data_p1_i = regs[r_reg_p1_o];
    r_data_p2_i = regs[r_reg_p2_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_inst(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                          input logic u1, input logic u2, input logic [4:0] d, input logic w);
    inst_valid_i = v; rs1_i = s1; rs2_i = s2;
    use_rs1_i = u1; use_rs2_i = u2; rd_i = d; rd_wr_i = w;
  endtask

  task automatic cycle(input string name, input logic exp_rdy, input logic [31:0] e1,
                       input logic [31:0] e2, input logic e_rdwr);
    iss_pkt_t p;
    @(negedge clk);
    chk(name, 32'(inst_ready_o), 32'(exp_rdy));
    if (inst_valid_i && inst_ready_o) begin
      p.rs1_data = e1; p.rs2_data = e2; p.rd = rd_i; p.rd_wr = e_rdwr;
      sb_q.push_back(p);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every packet consumed by execute is checked against the queue head.
  initial begin
    iss_pkt_t e;
    forever begin
      @(negedge clk);
      if (!reset && iss_valid_o && iss_ready_i) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_unexpected: got rd 0x%0h, expected no packet", iss_rd_o);
        end else begin
          e = sb_q.pop_front();
          chk("iss_rs1_data", iss_rs1_data_o, e.rs1_data);
          chk("iss_rs2_data", iss_rs2_data_o, e.rs2_data);
          chk("iss_rd", 32'(iss_rd_o), 32'(e.rd));
          chk("iss_rd_wr", 32'(iss_rd_wr_o), 32'(e.rd_wr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[5] = 32'h11; regs[6] = 32'h22;
    reset = 1'b1; wb_en_i = 1'b0; wb_reg_i = 5'd0; wb_data = 32'h0; iss_ready_i = 1'b1;
    set_inst(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("rst_iss_valid", 32'(iss_valid_o), 32'h0);
    chk("rst_out_cnt", 32'(out_cnt_o), 32'h0);
    chk("rst_iss_rs1", iss_rs1_data_o, 32'h0);
    chk("rst_iss_rd", 32'(iss_rd_o), 32'h0);
    @(posedge clk); #1; reset = 1'b0;

    // Basic add x7 = x5 + x6
    set_inst(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1);
    cycle("add_ready", 1'b1, 32'h11, 32'h22, 1'b1);
    inst_valid_i = 1'b0;
    @(negedge clk);
    chk("add_iss_valid", 32'(iss_valid_o), 32'h1);
    chk("add_out_cnt", 32'(out_cnt_o), 32'h1);
    @(posedge clk); #1;

    // RAW on x7, writeback 0x99 releases it one cycle later
    set_inst(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0);
    cycle("raw_stall", 1'b0, 32'h0, 32'h0, 1'b0);
    wb_en_i = 1'b1; wb_reg_i = 5'd7; wb_data = 32'h99;
    cycle("raw_stall_wb_cycle", 1'b0, 32'h0, 32'h0, 1'b0);
    wb_en_i = 1'b0;
    cycle("raw_accept", 1'b1, 32'h99, 32'h0, 1'b0);
    inst_valid_i = 1'b0;
    @(negedge clk);
    chk("raw_out_cnt", 32'(out_cnt_o), 32'h0);
    @(posedge clk); #1;

    // x0 destination is never tracked
    set_inst(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd0, 1'b1);
    cycle("x0_ready", 1'b1, 32'h11, 32'h22, 1'b0);
    set_inst(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0);
    cycle("x0_src_ready", 1'b1, 32'h0, 32'h0, 1'b0);
    inst_valid_i = 1'b0;
    @(negedge clk);
    chk("x0_out_cnt", 32'(out_cnt_o), 32'h0);
    @(posedge clk); #1;

    // Outstanding-write capacity
    for (int i = 1; i <= 4; i++) begin
      set_inst(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'(i), 1'b1);
      cycle("cap_fill", 1'b1, 32'h11, 32'h22, 1'b1);
    end
    inst_valid_i = 1'b0;
    @(negedge clk);
    chk("cap_out_cnt_full", 32'(out_cnt_o), 32'h4);
    @(posedge clk); #1;
    set_inst(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1);
    cycle("cap_full_stall", 1'b0, 32'h0, 32'h0, 1'b0);
    set_inst(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b0);
    cycle("cap_nowr_ready", 1'b1, 32'h11, 32'h22, 1'b0);
    set_inst(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1);
    wb_en_i = 1'b1; wb_reg_i = 5'd1; wb_data = 32'h55;
    cycle("cap_wb_cycle", 1'b0, 32'h0, 32'h0, 1'b0);
    wb_en_i = 1'b0;
    cycle("cap_after_wb", 1'b1, 32'h11, 32'h22, 1'b1);
    inst_valid_i = 1'b0;
    @(negedge clk);
    chk("cap_out_cnt_refill", 32'(out_cnt_o), 32'h4);
    @(posedge clk); #1;

    // Backpressure from execute
    iss_ready_i = 1'b0;
    set_inst(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd11, 1'b0);
    cycle("bp_first", 1'b1, 32'h55, 32'h11, 1'b0);
    set_inst(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 5'd12, 1'b0);
    cycle("bp_blocked", 1'b0, 32'h0, 32'h0, 1'b0);
    cycle("bp_blocked", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("bp_hold_valid", 32'(iss_valid_o), 32'h1);
    chk("bp_hold_rs1", iss_rs1_data_o, 32'h55);
    chk("bp_hold_rd", 32'(iss_rd_o), 32'd11);
    iss_ready_i = 1'b1;
    cycle("bp_release", 1'b1, 32'h22, 32'h11, 1'b0);
    inst_valid_i = 1'b0;
    @(negedge clk);
    chk("bp_second_rd", 32'(iss_rd_o), 32'd12);
    @(posedge clk); #1;

    // Drain outstanding writes
    wb_data = 32'h0;
    foreach (sb_q[i]) ;
    for (int i = 0; i < 4; i++) begin
      wb_en_i = 1'b1;
      wb_reg_i = (i == 3) ? 5'd8 : 5'(i + 2);
      @(posedge clk); #1;
    end
    wb_en_i = 1'b0;
    @(negedge clk);
    chk("drain_out_cnt", 32'(out_cnt_o), 32'h0);
    @(posedge clk); #1;

    // Reset with busy x7 and a held issue packet
    iss_ready_i = 1'b0;
    set_inst(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1);
    cycle("rst_setup", 1'b1, 32'h11, 32'h22, 1'b1);
    inst_valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(iss_valid_o), 32'h1);
    chk("pre_rst_out_cnt", 32'(out_cnt_o), 32'h1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(iss_valid_o), 32'h0);
    chk("async_rst_out_cnt", 32'(out_cnt_o), 32'h0);
    chk("async_rst_rs1", iss_rs1_data_o, 32'h0);
    chk("async_rst_rd_wr", 32'(iss_rd_wr_o), 32'h0);
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0; iss_ready_i = 1'b1;
    wb_en_i = 1'b1; wb_reg_i = 5'd7; wb_data = 32'h77;
    @(posedge clk); #1;
    wb_en_i = 1'b0;
    @(negedge clk);
    chk("stale_wb_out_cnt", 32'(out_cnt_o), 32'h0);
    @(posedge clk); #1;
    set_inst(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1);
    cycle("post_rst_rd7", 1'b1, 32'h77, 32'h0, 1'b1);
    inst_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_out_cnt", 32'(out_cnt_o), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_queue_empty", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
